// File: rtl/smoldvi_pixel_fifo.sv
// smoldvi_pixel_fifo
//
// Frame-aligned pixel FIFO that feeds smoldvi in the clk_pix domain. A producer
// pushes 24-bit pixels tagged with start-of-frame. The FIFO presents r/g/b to the
// DVI core and pops one pixel on each rgb_rdy beat. It also tracks the scan
// position the DVI core is consuming. On underflow or loss of frame alignment it
// drops back to SEEK, and it re-locks at the next (0,0) that has a sof head.
//
// Ports:
//   clk_pix        pixel clock, shared with smoldvi
//   rst_pix        synchronous active-high reset
//   in_valid       producer has a pixel
//   in_ready       FIFO can accept; a push happens on in_valid && in_ready
//   in_rgb         {r,g,b} pixel, r in [23:16]
//   in_sof         pixel is (0,0) of a frame
//   r, g, b        colour to smoldvi
//   rgb_rdy        smoldvi consumed the current r/g/b this cycle
//   level          occupancy, 0..2^DEPTH_LOG2
//   underflow_cnt  saturating count of underflow events
//   resync         one-cycle pulse after leaving LOCKED
//
// Optional feature macro: SMOLDVI_PIXEL_FIFO_SEEK_COLOUR_EN
//   When defined, SEEK shows magenta (24'hFF00FF) instead of FILL_RGB unless the
//   head is about to lock, so loss of lock is visible on screen.

module smoldvi_pixel_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter int          X_PIXELS   = 320,
    parameter int          Y_LINES    = 480,
    parameter logic [23:0] FILL_RGB   = 24'h000000
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [23:0]           in_rgb,
    input  logic                  in_sof,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    input  logic                  rgb_rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underflow_cnt,
    output logic                  resync
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int XW    = (X_PIXELS > 1) ? $clog2(X_PIXELS) : 1;
    localparam int YW    = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;

    localparam logic [XW-1:0]       X_LAST     = XW'(X_PIXELS - 1);
    localparam logic [YW-1:0]       Y_LAST     = YW'(Y_LINES - 1);
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef SMOLDVI_PIXEL_FIFO_SEEK_COLOUR_EN
    localparam logic [23:0] SEEK_RGB = 24'hFF00FF;
`else
    localparam logic [23:0] SEEK_RGB = FILL_RGB;
`endif

    typedef enum logic [0:0] {
        StSeek,
        StLocked
    } state_t;

    state_t state_q, state_d;

    // Storage: {sof, rgb}. Contents need no reset; occupancy is tracked by level_q.
    logic [24:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [15:0]           ucnt_q, ucnt_d;
    logic                  resync_q, resync_d;

    logic        empty;
    logic        full;
    logic        head_sof;
    logic [23:0] head_rgb;
    logic        pos0;
    logic        lock_now;
    logic        push;
    logic        pop;
    logic [23:0] rgb_out;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);
    assign head_sof = mem[rd_ptr_q][24];
    assign head_rgb = mem[rd_ptr_q][23:0];
    assign pos0     = (x_q == '0) && (y_q == '0);
    assign lock_now = (state_q == StSeek) && !empty && head_sof && pos0;
    assign push     = in_valid && !full;

    // Next-state, pop and event decode.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        resync_d = 1'b0;
        ucnt_d   = ucnt_q;
        unique case (state_q)
            StSeek: begin
                if (!empty) begin
                    if (!head_sof) begin
                        // Stale mid-frame pixels are drained as fast as possible.
                        pop = 1'b1;
                    end else if (pos0) begin
                        state_d = StLocked;
                        pop     = rgb_rdy;
                    end
                end
            end
            StLocked: begin
                if (rgb_rdy) begin
                    if (empty) begin
                        if (ucnt_q != 16'hFFFF) begin
                            ucnt_d = ucnt_q + 16'd1;
                        end
                        state_d  = StSeek;
                        resync_d = 1'b1;
                    end else if (head_sof != pos0) begin
                        // Head is not where the scan is: keep it for SEEK to judge.
                        state_d  = StSeek;
                        resync_d = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StSeek;
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Colour selection.
    always_comb begin
        rgb_out = FILL_RGB;
        if (state_q == StSeek) begin
            rgb_out = lock_now ? head_rgb : SEEK_RGB;
        end else if (!empty) begin
            rgb_out = head_rgb;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_sof, in_rgb};
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q  <= StSeek;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ucnt_q   <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            ucnt_q   <= ucnt_d;
            resync_q <= resync_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Scan position of the DVI core; advances on every consumed beat in any state.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            x_q <= '0;
            y_q <= '0;
        end else if (rgb_rdy) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign in_ready      = !full;
    assign level         = level_q;
    assign underflow_cnt = ucnt_q;
    assign resync        = resync_q;
    assign r             = rgb_out[23:16];
    assign g             = rgb_out[15:8];
    assign b             = rgb_out[7:0];

endmodule

// File: tb/tb_smoldvi_pixel_fifo.sv
module tb_smoldvi_pixel_fifo;

    localparam int          XP       = 8;
    localparam int          YP       = 4;
    localparam int          FRAME    = XP * YP;
    localparam int          DEPTH    = 16;
    localparam logic [23:0] FILL     = 24'h101010;
`ifdef SMOLDVI_PIXEL_FIFO_SEEK_COLOUR_EN
    localparam logic [23:0] SEEK_RGB = 24'hFF00FF;
`else
    localparam logic [23:0] SEEK_RGB = FILL;
`endif

    logic        clk_pix = 1'b0;
    logic        rst_pix = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_rgb = '0;
    logic        in_sof = 1'b0;
    logic [7:0]  r, g, b;
    logic        rgb_rdy = 1'b0;
    logic [4:0]  level;
    logic [15:0] underflow_cnt;
    logic        resync;

    smoldvi_pixel_fifo #(
        .DEPTH_LOG2 (4),
        .X_PIXELS   (XP),
        .Y_LINES    (YP),
        .FILL_RGB   (FILL)
    ) dut (
        .clk_pix       (clk_pix),
        .rst_pix       (rst_pix),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rgb        (in_rgb),
        .in_sof        (in_sof),
        .r             (r),
        .g             (g),
        .b             (b),
        .rgb_rdy       (rgb_rdy),
        .level         (level),
        .underflow_cnt (underflow_cnt),
        .resync        (resync)
    );

    always #5 clk_pix = ~clk_pix;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a queue of {sof, rgb}, a lock flag and the scan position.
    logic [24:0] q[$];
    bit          m_locked;
    int          m_x, m_y;
    int          m_ucnt;
    bit          m_resync;

    // Producer stream state.
    int          sidx;
    int          corrupt_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked = 0;
        m_x      = 0;
        m_y      = 0;
        m_ucnt   = 0;
        m_resync = 0;
    endtask

    // One clock: drive inputs at negedge, compare DUT to the model, then advance the model.
    task automatic cycle(input bit rst, input bit v, input logic [23:0] rgb, input bit sof,
                         input bit rdy);
        logic [23:0] exp_rgb;
        bit          pos0, push, pop, nlocked, nres;
        @(negedge clk_pix);
        rst_pix  = rst;
        in_valid = v;
        in_rgb   = rgb;
        in_sof   = sof;
        rgb_rdy  = rdy;
        #1;
        pos0 = (m_x == 0) && (m_y == 0);
        if (m_locked) begin
            exp_rgb = (q.size() > 0) ? q[0][23:0] : FILL;
        end else begin
            exp_rgb = (q.size() > 0 && q[0][24] && pos0) ? q[0][23:0] : SEEK_RGB;
        end
        chk("rgb", {8'h0, r, g, b}, {8'h0, exp_rgb});
        chk("level", {27'h0, level}, q.size());
        chk("in_ready", {31'h0, in_ready}, {31'h0, q.size() < DEPTH});
        chk("underflow_cnt", {16'h0, underflow_cnt}, m_ucnt);
        chk("resync", {31'h0, resync}, {31'h0, m_resync});
        if (rst) begin
            model_reset();
            return;
        end
        push    = v && (q.size() < DEPTH);
        pop     = 0;
        nres    = 0;
        nlocked = m_locked;
        if (!m_locked) begin
            if (q.size() > 0) begin
                if (!q[0][24]) pop = 1;
                else if (pos0) begin
                    nlocked = 1;
                    pop     = rdy;
                end
            end
        end else if (rdy) begin
            if (q.size() == 0) begin
                if (m_ucnt < 65535) m_ucnt++;
                nlocked = 0;
                nres    = 1;
            end else if (q[0][24] != pos0) begin
                nlocked = 0;
                nres    = 1;
            end else begin
                pop = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back({sof, rgb});
        if (rdy) begin
            m_x = (m_x + 1) % XP;
            if (m_x == 0) m_y = (m_y + 1) % YP;
        end
        m_locked = nlocked;
        m_resync = nres;
    endtask

    // Next producer pixel from a well-formed stream; sof on every frame boundary unless
    // corrupted at index corrupt_at, or randomly with probability flip_pct.
    task automatic stream_cycle(input int vprob, input int rprob, input int flip_pct);
        bit          v, rdy, sof, acc;
        logic [23:0] rgb;
        v   = ($urandom_range(99) < vprob);
        rdy = ($urandom_range(99) < rprob);
        sof = ((sidx % FRAME) == 0);
        if (sidx == corrupt_at) sof = 1'b1;
        if ($urandom_range(99) < flip_pct) sof = ~sof;
        rgb = 24'($urandom());
        acc = v && (q.size() < DEPTH);
        cycle(0, v, rgb, sof, rdy);
        if (acc) sidx++;
    endtask

    // Observe the DUT just after the edge that consumed the last driven inputs.
    task automatic peek();
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        corrupt_at = -1;
        sidx       = 0;
        repeat (2) @(posedge clk_pix);
        model_reset();

        // Idle producer, a beat every 5 cycles, two full frames of position.
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < FRAME * 2 * 5; i++) cycle(0, 0, '0, 0, (i % 5) == 4);
        peek();
        chk("idle_ucnt", {16'h0, underflow_cnt}, 32'd0);
        chk("idle_level", {27'h0, level}, 32'd0);
        chk("idle_ready", {31'h0, in_ready}, 32'd1);
        chk("idle_rgb", {8'h0, r, g, b}, {8'h0, SEEK_RGB});

        // Aligned frame starting with 0x112233, continuously fed for three frames.
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, 24'h112233, 1, 0);
        sidx = 1;
        for (int i = 0; i < 3; i++) stream_cycle(100, 0, 0);
        peek();
        chk("first_pixel", {8'h0, r, g, b}, 32'h00112233);
        chk("prefill_level", {27'h0, level}, 32'd4);
        for (int i = 0; i < 3 * FRAME; i++) stream_cycle(100, 100, 0);
        peek();
        chk("locked_ucnt", {16'h0, underflow_cnt}, 32'd0);

        // Producer stall: one underflow, then drain stale pixels and relock at next frame.
        for (int i = 0; i < 20; i++) cycle(0, 0, '0, 0, 1);
        peek();
        chk("underflow_one", {16'h0, underflow_cnt}, 32'd1);
        for (int i = 0; i < 200; i++) stream_cycle(100, 50, 0);
        peek();
        chk("relock_ucnt", {16'h0, underflow_cnt}, 32'd1);

        // Spurious sof at index 5 of the next frame.
        corrupt_at = ((sidx / FRAME) + 1) * FRAME + 5;
        for (int i = 0; i < 300; i++) stream_cycle(100, 50, 0);
        corrupt_at = -1;

        // Fill to full with no consumption, then pop at full and push+pop at 15.
        cycle(1, 0, '0, 0, 0);
        sidx = 0;
        for (int i = 0; i < 20; i++) stream_cycle(100, 0, 0);
        peek();
        chk("full_level", {27'h0, level}, 32'd16);
        chk("full_ready", {31'h0, in_ready}, 32'd0);
        cycle(0, 1, 24'hABCDEF, 0, 1);
        peek();
        chk("pop_at_full", {27'h0, level}, 32'd15);
        cycle(0, 1, 24'h123456, 0, 1);
        peek();
        chk("push_pop_level", {27'h0, level}, 32'd15);

        // Random traffic with occasional sof corruption and a reset mid-run.
        for (int i = 0; i < 1500; i++) stream_cycle(70, 60, 3);
        cycle(1, 1, 24'h55AA55, 0, 1);
        peek();
        chk("rst_level", {27'h0, level}, 32'd0);
        chk("rst_ucnt", {16'h0, underflow_cnt}, 32'd0);
        for (int i = 0; i < 1500; i++) stream_cycle(80, 60, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
